// File: rtl/aes_pkg.sv
// AES column-mix shared types, widths and GF(2^8) helpers.
// Exports: STATE_W, COL_W, NUM_COLS, byte_t, col_t, fsm_e, RED_POLY, xtime().
package aes_pkg;

  localparam int STATE_W  = 128;
  localparam int COL_W    = 32;
  localparam int NUM_COLS = 4;

  typedef logic [7:0]       byte_t;
  typedef logic [COL_W-1:0] col_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } fsm_e;

  localparam byte_t RED_POLY = 8'h1b;

  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? RED_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/mix_column_unit.sv
// Combinational (Inv)MixColumns of one 32-bit column, row 0 in [31:24].
// Ports: col_i column in, inv_i inverse select, col_o column out. Macro: AES_INV_MIX_EN.
module mix_column_unit
  import aes_pkg::*;
(
  input  col_t col_i,
  input  logic inv_i,
  output col_t col_o
);

  byte_t [0:3] a;
  byte_t [0:3] fwd;

  assign a = col_i;

  always_comb begin
    fwd = '0;
    for (int r = 0; r < 4; r++) begin
      fwd[r] = xtime(a[r])
             ^ xtime(a[2'(r + 1)]) ^ a[2'(r + 1)]
             ^ a[2'(r + 2)]
             ^ a[2'(r + 3)];
    end
  end

`ifdef AES_INV_MIX_EN
  byte_t [0:3] x2;
  byte_t [0:3] x4;
  byte_t [0:3] x8;
  byte_t [0:3] bwd;

  // Multiples 2,4,8 per byte; 0e/0b/0d/09 are XOR combinations of them.
  always_comb begin
    x2  = '0;
    x4  = '0;
    x8  = '0;
    bwd = '0;
    for (int r = 0; r < 4; r++) begin
      x2[r] = xtime(a[r]);
      x4[r] = xtime(x2[r]);
      x8[r] = xtime(x4[r]);
    end
    for (int r = 0; r < 4; r++) begin
      bwd[r] = (x8[r] ^ x4[r] ^ x2[r])
             ^ (x8[2'(r + 1)] ^ x2[2'(r + 1)] ^ a[2'(r + 1)])
             ^ (x8[2'(r + 2)] ^ x4[2'(r + 2)] ^ a[2'(r + 2)])
             ^ (x8[2'(r + 3)] ^ a[2'(r + 3)]);
    end
  end

  assign col_o = inv_i ? bwd : fwd;
`else
  logic unused_inv;
  assign unused_inv = inv_i;
  assign col_o      = fwd;
`endif

endmodule

// File: rtl/mix_columns_iter.sv
// Iterative MixColumns over a 128-bit state, COLS_PER_CYCLE columns per cycle.
// Ports: clk, rst, in_valid/in_ready/in_state/in_inv, out_valid/out_ready/out_state, busy. Macro: AES_INV_MIX_EN.
module mix_columns_iter
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_state,
  input  logic               in_inv,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_state,
  output logic               busy
);

  // STEP of 4 truncates to 0, which is the correct wrap for a 2-bit counter.
  localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_OFS = 2'(COLS_PER_CYCLE - 1);

  fsm_e                   state_q, state_d;
  logic [1:0]             cnt_q, cnt_d;
  col_t [0:NUM_COLS-1]    cols_q, cols_d;
  logic                   inv_q;
  logic                   accept;
  logic                   last;

  logic [1:0] idx     [COLS_PER_CYCLE];
  col_t       col_in  [COLS_PER_CYCLE];
  col_t       col_out [COLS_PER_CYCLE];

  assign accept    = in_valid & in_ready;
  assign last      = (cnt_q + LAST_OFS) == 2'd3;
  assign out_state = cols_q;

  for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
    assign idx[k]    = cnt_q + 2'(k);
    assign col_in[k] = cols_q[idx[k]];

    mix_column_unit u_mc (
      .col_i (col_in[k]),
      .inv_i (inv_q),
      .col_o (col_out[k])
    );
  end

`ifdef AES_INV_MIX_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      inv_q <= 1'b0;
    end else if (accept) begin
      inv_q <= in_inv;
    end
  end
`else
  logic unused_inv;
  assign unused_inv = in_inv;
  assign inv_q      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cols_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cols_q  <= cols_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = CALC;
      CALC: if (last) state_d = DONE;
      DONE: if (out_ready) state_d = in_valid ? CALC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE: in_ready = 1'b1;
      CALC: busy = 1'b1;
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: ;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    cols_d = cols_q;
    if (accept) begin
      cols_d = in_state;
      cnt_d  = '0;
    end else if (state_q == CALC) begin
      for (int k = 0; k < COLS_PER_CYCLE; k++) begin
        cols_d[idx[k]] = col_out[k];
      end
      cnt_d = cnt_q + STEP;
    end
  end

endmodule

// File: tb/tb_mix_columns_iter.sv
// Bench for mix_columns_iter: N=1, 2 and 4 instances against a GF(2^8) matrix model.
// Ports: all DUT ports driven/observed; clock generated locally.
module tb_mix_columns_iter;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] in_state;
  logic         in_inv;
  logic         out_ready;
  logic         in_valid_a  [3];
  logic         in_ready_a  [3];
  logic         out_valid_a [3];
  logic         busy_a      [3];
  logic [127:0] out_state_a [3];

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mix_columns_iter #(.COLS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]),
    .in_state(in_state), .in_inv(in_inv),
    .out_valid(out_valid_a[0]), .out_ready(out_ready),
    .out_state(out_state_a[0]), .busy(busy_a[0])
  );

  mix_columns_iter #(.COLS_PER_CYCLE(2)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]),
    .in_state(in_state), .in_inv(in_inv),
    .out_valid(out_valid_a[1]), .out_ready(out_ready),
    .out_state(out_state_a[1]), .busy(busy_a[1])
  );

  mix_columns_iter #(.COLS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_a[2]), .in_ready(in_ready_a[2]),
    .in_state(in_state), .in_inv(in_inv),
    .out_valid(out_valid_a[2]), .out_ready(out_ready),
    .out_state(out_state_a[2]), .busy(busy_a[2])
  );

  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p, m;
    p = '0;
    m = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ m;
      m = {m[6:0], 1'b0} ^ (m[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s, input logic inv);
    logic [7:0]   cf [4];
    logic [7:0]   a  [4];
    logic [7:0]   b;
    logic [127:0] r;
    logic         use_inv;
`ifdef AES_INV_MIX_EN
    use_inv = inv;
`else
    use_inv = 1'b0;
`endif
    if (use_inv) cf = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else         cf = '{8'h02, 8'h03, 8'h01, 8'h01};
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) a[j] = s[127-32*c-8*j -: 8];
      for (int rr = 0; rr < 4; rr++) begin
        b = '0;
        for (int j = 0; j < 4; j++) b = b ^ gmul(cf[(j - rr + 4) % 4], a[j]);
        r[127-32*c-8*rr -: 8] = b;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input int d, input logic [127:0] s, input logic inv,
                      input int exp_lat, input string tag);
    int lat;
    logic [127:0] exp;
    exp = model(s, inv);
    in_state      = s;
    in_inv        = inv;
    in_valid_a[d] = 1'b1;
    chk({tag, "_rdy"}, 128'(in_ready_a[d]), 128'(1));
    step();
    in_valid_a[d] = 1'b0;
    chk({tag, "_busy"}, 128'(busy_a[d]), 128'(1));
    lat = 0;
    while (!out_valid_a[d] && lat < 20) begin
      step();
      lat++;
    end
    chk({tag, "_lat"}, 128'(lat), 128'(exp_lat));
    chk({tag, "_out"}, out_state_a[d], exp);
    step();
  endtask

  initial begin
    logic [127:0] s, exp, cur;
    logic         cur_inv, acc, seen;
    int           lat, cyc, nout, n;
    logic [127:0] expq[$];
    int           accq[$];

    rst       = 1'b1;
    in_state  = '0;
    in_inv    = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) in_valid_a[i] = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    chk("rst_valid", 128'(out_valid_a[0]), 128'(0));
    chk("rst_busy", 128'(busy_a[0]), 128'(0));
    chk("rst_rdy", 128'(in_ready_a[0]), 128'(1));
    chk("rst_out", out_state_a[0], 128'h0);
    chk("rst_out4", out_state_a[2], 128'h0);

    s = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    xfer(0, s, 1'b0, 4, "fwd");
    chk("fwd_hold", out_state_a[0], 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6);

    s = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    xfer(0, s, 1'b1, 4, "inv");
`ifdef AES_INV_MIX_EN
    chk("inv_vec", out_state_a[0], 128'hdb135345_f20a225c_01010101_c6c6c6c6);
`endif

    for (int i = 0; i < 6; i++) xfer(0, rnd128(), 1'($urandom), 4, "rnd");

    s   = rnd128();
    exp = model(s, 1'b0);
    out_ready     = 1'b0;
    in_state      = s;
    in_inv        = 1'b0;
    in_valid_a[0] = 1'b1;
    step();
    in_state = rnd128();
    lat = 0;
    while (!out_valid_a[0] && lat < 20) begin
      step();
      lat++;
      in_state = rnd128();
      in_inv   = 1'($urandom);
    end
    chk("bp_lat", 128'(lat), 128'(4));
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", 128'(out_valid_a[0]), 128'(1));
      chk("bp_state", out_state_a[0], exp);
      chk("bp_rdy", 128'(in_ready_a[0]), 128'(0));
      step();
      in_state = rnd128();
    end
    in_valid_a[0] = 1'b0;
    out_ready     = 1'b1;
    step();
    chk("bp_idle", 128'(busy_a[0]), 128'(0));
    chk("bp_keep", out_state_a[0], exp);

    cur = rnd128();
    cur_inv = 1'($urandom);
    in_state = cur;
    in_inv   = cur_inv;
    in_valid_a[0] = 1'b1;
    cyc  = 0;
    nout = 0;
    while (nout < 4 && cyc < 80) begin
      if (out_valid_a[0]) begin
        chk("b2b_q", 128'(expq.size() > 0), 128'(1));
        if (expq.size() > 0) begin
          chk("b2b_out", out_state_a[0], expq[0]);
          chk("b2b_lat", 128'(cyc - accq[0]), 128'(4));
          void'(expq.pop_front());
          void'(accq.pop_front());
        end
        chk("b2b_rdy", 128'(in_ready_a[0]), 128'(1));
        nout++;
      end
      acc = in_valid_a[0] & in_ready_a[0];
      step();
      cyc++;
      if (acc) begin
        expq.push_back(model(cur, cur_inv));
        accq.push_back(cyc);
      end
      cur = rnd128();
      cur_inv = 1'($urandom);
      in_state = cur;
      in_inv   = cur_inv;
    end
    chk("b2b_cnt", 128'(nout), 128'(4));
    in_valid_a[0] = 1'b0;
    n = 0;
    while (busy_a[0] && n < 20) begin
      step();
      n++;
    end
    chk("b2b_drain", 128'(busy_a[0]), 128'(0));

    in_state      = rnd128();
    in_inv        = 1'b0;
    in_valid_a[0] = 1'b1;
    step();
    in_valid_a[0] = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("ab_busy", 128'(busy_a[0]), 128'(0));
    chk("ab_rdy", 128'(in_ready_a[0]), 128'(1));
    chk("ab_out", out_state_a[0], 128'h0);
    seen = 1'b0;
    repeat (8) begin
      step();
      seen = seen | out_valid_a[0];
    end
    chk("ab_novalid", 128'(seen), 128'(0));
    xfer(0, {32'hd4d4d4d5, $urandom, $urandom, $urandom}, 1'b0, 4, "ab_next");
    chk("ab_col0", 128'(out_state_a[0][127:96]), 128'(32'hd5d5d7d6));

    xfer(1, {32'h2d26314c, $urandom, $urandom, $urandom}, 1'b0, 2, "n2");
    chk("n2_col0", 128'(out_state_a[1][127:96]), 128'(32'h4d7ebdf8));
    xfer(2, {32'h2d26314c, $urandom, $urandom, $urandom}, 1'b0, 1, "n4");
    chk("n4_col0", 128'(out_state_a[2][127:96]), 128'(32'h4d7ebdf8));
    for (int i = 0; i < 3; i++) begin
      xfer(1, rnd128(), 1'($urandom), 2, "n2r");
      xfer(2, rnd128(), 1'($urandom), 1, "n4r");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
